// File: rtl/ring_buffer_trigger_ctrl.sv
// Trigger sequencer for one ring buffer: on an accepted trigger it holds the
// buffer write enable for one frame (pre-trigger history from the delay line,
// the trigger sample, then the post-trigger samples), then drains exactly that
// frame from the buffer FIFO onto a valid/ready stream with a last-word marker.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | tracking config, waiting for a trigger on a settled delay line
// CAPTURE | buffer WE held high, counting written samples
// DRAIN   | streaming the captured frame out of the buffer FIFO
module ring_buffer_trigger_ctrl #(
    parameter int WIDTH          = 128,
    parameter int MAX_BACK_LEN   = 40,
    parameter int POST_LEN_WIDTH = 8,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int BL_W  = $clog2(MAX_BACK_LEN),
    localparam int CNT_W = $clog2(MAX_BACK_LEN + 2**POST_LEN_WIDTH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_trig,
    input  logic [BL_W-1:0]           i_cfg_back_len,
    input  logic [POST_LEN_WIDTH-1:0] i_cfg_post_len,
    output logic [BL_W-1:0]           o_back_len,
    output logic                      o_buff_we,
    output logic                      o_buff_re,
    input  logic                      i_buff_write_ready,
    input  logic                      i_buff_read_valid,
    input  logic                      i_buff_almost_full,
    input  logic [WIDTH-1:0]          i_buff_dout,
    output logic [WIDTH-1:0]          o_m_data,
    output logic                      o_m_valid,
    input  logic                      i_m_ready,
    output logic                      o_m_last,
    output logic                      o_m_trunc,
    output logic                      o_busy,
    output logic [DROP_CNT_WIDTH-1:0] o_trig_drop_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [1:0]                r_state;
    logic [BL_W-1:0]           r_back_len;
    logic [POST_LEN_WIDTH-1:0] r_post_len;
    logic [CNT_W-1:0]          r_len;
    logic [CNT_W-1:0]          r_wr_cnt;
    logic [CNT_W-1:0]          r_frame_len;
    logic [CNT_W-1:0]          r_rd_cnt;
    logic                      r_trunc;
    logic                      r_we;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    logic             w_in_idle;
    logic             w_in_drain;
    logic             w_accept;
    logic             w_m_valid;
    logic             w_m_last;
    logic             w_buff_re;
    logic [CNT_W-1:0] w_wr_next;
    logic             w_cap_exit;

    // Acceptance requires the delay line to already reflect the requested length.
    assign w_in_idle  = (r_state == S_IDLE);
    assign w_in_drain = (r_state == S_DRAIN);
    assign w_accept   = w_in_idle && i_trig && i_buff_write_ready
                        && (i_cfg_back_len == r_back_len);
    assign w_m_valid  = w_in_drain && i_buff_read_valid;
    assign w_m_last   = w_m_valid && (r_rd_cnt == r_frame_len - C_ONE);
    assign w_buff_re  = w_m_valid && i_m_ready;
    assign w_wr_next  = r_wr_cnt + C_ONE;
    assign w_cap_exit = (r_state == S_CAPTURE) && r_we
                        && ((r_wr_cnt == r_len - C_ONE) || i_buff_almost_full);

    // Frame sequencing: capture length, write count, drain count, truncation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_back_len  <= '0;
            r_post_len  <= '0;
            r_len       <= '0;
            r_wr_cnt    <= '0;
            r_frame_len <= '0;
            r_rd_cnt    <= '0;
            r_trunc     <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_back_len <= i_cfg_back_len;
                    r_post_len <= i_cfg_post_len;
                    if (w_accept) begin
                        r_len    <= CNT_W'(r_back_len) + CNT_W'(r_post_len) + C_ONE;
                        r_wr_cnt <= '0;
                        r_trunc  <= 1'b0;
                        r_we     <= 1'b1;
                        r_state  <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (r_we) begin
                        r_wr_cnt <= w_wr_next;
                    end
                    if (w_cap_exit) begin
                        // The exit cycle still writes, so the frame holds wr_cnt+1 words.
                        r_frame_len <= w_wr_next;
                        r_trunc     <= (w_wr_next < r_len);
                        r_we        <= 1'b0;
                        r_rd_cnt    <= '0;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_buff_re) begin
                        r_rd_cnt <= r_rd_cnt + C_ONE;
                        if (w_m_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of every trigger that did not start a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_drop_cnt <= '0;
        end else if (i_trig && !w_accept && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    assign o_back_len      = r_back_len;
    assign o_buff_we       = r_we;
    assign o_buff_re       = w_buff_re;
    assign o_m_data        = i_buff_dout;
    assign o_m_valid       = w_m_valid;
    assign o_m_last        = w_m_last;
    assign o_m_trunc       = w_m_last && r_trunc;
    assign o_busy          = !w_in_idle;
    assign o_trig_drop_cnt = r_drop_cnt;

endmodule
